id_grf_scoreboard: RTL and testbench

//   Parametrised register file plus pending-write scoreboard for the ID stage.
//   It replaces the fixed 2-read GRF and gives the hazard controller a per-port busy flag.
//   NUM_RD combinational read ports have write-first bypass from WB.
//   A per-register saturating counter tracks in-flight writes: incremented at issue, decremented at WB.

---
 rtl/id_grf_scoreboard_if.sv | 35 +++
 rtl/id_grf_scoreboard.sv | 124 ++++++++++++
 tb/tb_id_grf_scoreboard.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/id_grf_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : id_grf_scoreboard_if
// Purpose  : Read, issue, writeback and flush signals between the ID stage
//            and the register file / pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface id_grf_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_en;
  logic [AW-1:0]            iss_a3;
  logic                     wb_en;
  logic [AW-1:0]            wb_a3;
  logic [DATA_W-1:0]        wb_wd;
  logic [31:0]              wb_pc;
  logic                     flush;
  logic                     sb_err;

  modport master (
    output rd_addr, iss_en, iss_a3, wb_en, wb_a3, wb_wd, wb_pc, flush,
    input  rd_data, rd_busy, sb_err
  );

  modport slave (
    input  rd_addr, iss_en, iss_a3, wb_en, wb_a3, wb_wd, wb_pc, flush,
    output rd_data, rd_busy, sb_err
  );
endinterface
`default_nettype wire

// File: rtl/id_grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_grf_scoreboard
// Purpose  : GRF with NUM_RD bypassed read ports and per-register saturating
//            pending-write counters. Define GRF_TRACE_EN for a commit trace.
// Revision : 1.0 - initial release
// ============================================================================
module id_grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  id_grf_scoreboard_if.slave bus
);
  localparam int              NUM_REGS  = 2**AW;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
  logic              sb_err_q;
  logic              sb_err_d;

  logic [NUM_REGS-1:0]      w_inc;
  logic [NUM_REGS-1:0]      w_dec;
  logic                     w_wb_commit;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;
  logic [AW-1:0]            w_addr;
  logic [CNT_W-1:0]         w_cnt;
  logic                     w_ret;

  assign w_wb_commit = bus.wb_en && (bus.wb_a3 != '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (bus.iss_en && !bus.flush && (bus.iss_a3 != '0)) begin
      w_inc[bus.iss_a3] = 1'b1;
    end
    if (w_wb_commit) begin
      w_dec[bus.wb_a3] = 1'b1;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (w_wb_commit) begin
      regs_d[bus.wb_a3] = bus.wb_wd;
    end
  end

  // Errors are still detected on a flush cycle; the flush then wipes all counts.
  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (w_inc[r] && !w_dec[r]) begin
        if (cnt_q[r] == C_CNT_MAX) sb_err_d = 1'b1;
        else                       cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (w_dec[r] && !w_inc[r]) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    if (bus.flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_d[r] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  // Reads are forced to zero while reset is held so a live WB cannot leak through.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_addr    = '0;
    w_cnt     = '0;
    w_ret     = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_addr = bus.rd_addr[i*AW +: AW];
      w_cnt  = cnt_q[w_addr];
      w_ret  = bus.wb_en && (bus.wb_a3 == w_addr) && (w_cnt != '0);
      if (reset && (w_addr != '0)) begin
        w_rd_busy[i] = ((w_cnt - CNT_W'(w_ret)) != '0);
        w_rd_data[i*DATA_W +: DATA_W] =
          (bus.wb_en && (bus.wb_a3 == w_addr)) ? bus.wb_wd : regs_q[w_addr];
      end
    end
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_busy = w_rd_busy;
  assign bus.sb_err  = sb_err_q;

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && w_wb_commit) begin
      $display("@%h: $%d <= %h", bus.wb_pc, bus.wb_a3, bus.wb_wd);
    end
  end
`else
  logic unused_wb_pc;
  assign unused_wb_pc = ^bus.wb_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_grf_scoreboard
// Purpose  : Vector table, reset corner sequence and randomized run against a
//            behavioural model of the GRF and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_grf_scoreboard;
  localparam int C_MAX = 3;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  id_grf_scoreboard_if #(.DATA_W(32), .AW(5), .NUM_RD(2)) sb_if ();

  id_grf_scoreboard #(.DATA_W(32), .AW(5), .NUM_RD(2), .CNT_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int rst; int iss_en; int iss_a3; int wb_en; int wb_a3; int wb_wd; int flush;
    int a0; int a1; int d0; int d1; int b0; int b1; int err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  logic [31:0] m_reg [32];
  int          m_cnt [32];
  int          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int ie, input int ia, input int we, input int wa,
                       input int wd, input int fl, input int a0, input int a1);
    sb_if.iss_en  = 1'(ie);
    sb_if.iss_a3  = 5'(ia);
    sb_if.wb_en   = 1'(we);
    sb_if.wb_a3   = 5'(wa);
    sb_if.wb_wd   = 32'(wd);
    sb_if.wb_pc   = 32'h0040_3000 + 32'(wa * 4);
    sb_if.flush   = 1'(fl);
    sb_if.rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 0;
  endtask

  function automatic logic [31:0] exp_data(input int a);
    if (a == 0) return 32'h0;
    if (sb_if.wb_en && (int'(sb_if.wb_a3) == a)) return sb_if.wb_wd;
    return m_reg[a];
  endfunction

  // Busy means a write is still outstanding once this cycle's retire is counted.
  function automatic logic exp_busy(input int a);
    int pending;
    if (a == 0) return 1'b0;
    pending = m_cnt[a];
    if (sb_if.wb_en && (int'(sb_if.wb_a3) == a) && pending > 0) pending--;
    return pending != 0;
  endfunction

  task automatic model_step();
    for (int r = 1; r < 32; r++) begin
      bit inc;
      bit dec;
      inc = sb_if.iss_en && (int'(sb_if.iss_a3) == r) && !sb_if.flush;
      dec = sb_if.wb_en && (int'(sb_if.wb_a3) == r);
      if (inc && !dec) begin
        if (m_cnt[r] == C_MAX) m_err = 1;
        else                   m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1;
        else               m_cnt[r]--;
      end
    end
    if (sb_if.flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end
    if (sb_if.wb_en && sb_if.wb_a3 != 5'd0) m_reg[sb_if.wb_a3] = sb_if.wb_wd;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //            rst ie a3 we a3 wd            fl a0 a1 d0            d1            b0 b1 err
    vecs[0]  = '{1, 0, 0, 0, 0, 0,            0, 5, 0, 0,            0,            0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 8, 32'hDEADBEEF, 0, 8, 0, 32'hDEADBEEF, 0,            0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0,            0, 8, 8, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1};
    vecs[3]  = '{1, 1, 9, 0, 0, 0,            0, 9, 9, 0,            0,            0, 0, 0};
    vecs[4]  = '{0, 1, 9, 0, 0, 0,            0, 9, 9, 0,            0,            1, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 9, 32'h11,       0, 9, 0, 32'h11,       0,            1, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 9, 32'h22,       0, 9, 9, 32'h22,       32'h22,       0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0,            0, 9, 3, 32'h22,       0,            0, 0, 0};
    vecs[8]  = '{0, 1, 3, 0, 0, 0,            0, 3, 0, 0,            0,            0, 0, 0};
    vecs[9]  = '{0, 1, 3, 0, 0, 0,            0, 3, 0, 0,            0,            1, 0, 0};
    vecs[10] = '{0, 1, 3, 0, 0, 0,            0, 3, 0, 0,            0,            1, 0, 0};
    vecs[11] = '{0, 1, 3, 0, 0, 0,            0, 3, 0, 0,            0,            1, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 0,            0, 3, 0, 0,            0,            1, 0, 1};
    vecs[13] = '{1, 1, 4, 0, 0, 0,            0, 4, 0, 0,            0,            0, 0, 0};
    vecs[14] = '{0, 1, 4, 0, 0, 0,            1, 4, 0, 0,            0,            1, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0, 0,            0, 4, 0, 0,            0,            0, 0, 0};
    vecs[16] = '{0, 0, 0, 1, 0, 1,            0, 0, 0, 0,            0,            0, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0,            0, 0, 4, 0,            0,            0, 0, 0};

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].rst != 0) do_reset();
      drive(vecs[k].iss_en, vecs[k].iss_a3, vecs[k].wb_en, vecs[k].wb_a3,
            vecs[k].wb_wd, vecs[k].flush, vecs[k].a0, vecs[k].a1);
      #1;
      chk($sformatf("vec%0d.rd_data0", k), sb_if.rd_data[31:0],  32'(vecs[k].d0));
      chk($sformatf("vec%0d.rd_data1", k), sb_if.rd_data[63:32], 32'(vecs[k].d1));
      chk($sformatf("vec%0d.rd_busy0", k), 32'(sb_if.rd_busy[0]), 32'(vecs[k].b0));
      chk($sformatf("vec%0d.rd_busy1", k), 32'(sb_if.rd_busy[1]), 32'(vecs[k].b1));
      chk($sformatf("vec%0d.sb_err", k),   32'(sb_if.sb_err),     32'(vecs[k].err));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a cycle with live WB and pending entry.
    do_reset();
    drive(0, 0, 1, 10, 32'h5A5A, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 12, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 1, 10, 32'h77, 0, 10, 12);
    #1;
    chk("pre_rst.rd_data0", sb_if.rd_data[31:0], 32'h77);
    chk("pre_rst.rd_busy1", 32'(sb_if.rd_busy[1]), 32'h1);
    chk("pre_rst.sb_err",   32'(sb_if.sb_err), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("in_rst.rd_data0", sb_if.rd_data[31:0],  32'h0);
    chk("in_rst.rd_data1", sb_if.rd_data[63:32], 32'h0);
    chk("in_rst.rd_busy",  32'(sb_if.rd_busy),   32'h0);
    chk("in_rst.sb_err",   32'(sb_if.sb_err),    32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 10, 12);
    reset = 1'b1;
    #1;
    chk("post_rst.rd_data0", sb_if.rd_data[31:0], 32'h0);
    chk("post_rst.rd_busy1", 32'(sb_if.rd_busy[1]), 32'h0);
    drive(0, 0, 1, 12, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst.late_wb_err", 32'(sb_if.sb_err), 32'h1);

    // Randomized traffic over a small address window to force collisions.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int a0;
      int a1;
      a0 = int'($urandom_range(0, 7));
      a1 = int'($urandom_range(0, 7));
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom), ($urandom_range(0, 15) == 0) ? 1 : 0, a0, a1);
      #1;
      chk($sformatf("rnd%0d.rd_data0", c), sb_if.rd_data[31:0],  exp_data(a0));
      chk($sformatf("rnd%0d.rd_data1", c), sb_if.rd_data[63:32], exp_data(a1));
      chk($sformatf("rnd%0d.rd_busy0", c), 32'(sb_if.rd_busy[0]), 32'(exp_busy(a0)));
      chk($sformatf("rnd%0d.rd_busy1", c), 32'(sb_if.rd_busy[1]), 32'(exp_busy(a1)));
      chk($sformatf("rnd%0d.sb_err", c),   32'(sb_if.sb_err),     32'(m_err));
      @(posedge clk);
      model_step();
      #1;
      // Periodic reset keeps the sticky error flag from masking later checks.
      if ((c % 100) == 99) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
